// File: rtl/ad7606_sample_sched.sv
// rtl/ad7606_sample_sched.sv - AD7606 conversion sequencer: ADC reset, trigger timing, timeout and overrun tracking
//
// Sequences the AD7606 serial reader. Pulses the ADC RESET pin and waits for
// settling, then issues single-cycle caiji_flag starts from a periodic timer
// or a software single-shot. Each conversion is closed by rd_done or aborted
// by a timeout that re-initialises the ADC.
//
// Ports:
//   clk, res           clock, asynchronous active-high reset
//   enable, period     periodic trigger enable and interval (period 0 = timer off)
//   single_shot        one-cycle request for a single conversion
//   os_sel, range_sel  oversampling / range selection, copied to the ADC pins
//   reinit             one-cycle request to rerun the ADC reset sequence
//   clear_err          one-cycle clear of sticky flags and counters
//   rd_done            end-of-frame pulse from the reader
//   ad_reset, ad_os, ad_range   ADC static control pins
//   caiji_flag         one-cycle start pulse to the reader
//   ready              high while idle
//   overrun, overrun_cnt        dropped timer ticks (sticky / saturating count)
//   timeout_err        sticky: reader did not finish in time
//   sample_cnt         completed frames (wrapping)
module ad7606_sample_sched #(
    parameter int RST_CYCLES    = 10,
    parameter int SETTLE_CYCLES = 100,
    parameter int TIMEOUT       = 4096,
    parameter int PER_W         = 24
) (
    input  logic             clk,
    input  logic             res,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    input  logic             single_shot,
    input  logic [2:0]       os_sel,
    input  logic             range_sel,
    input  logic             reinit,
    input  logic             clear_err,
    input  logic             rd_done,
    output logic             ad_reset,
    output logic [2:0]       ad_os,
    output logic             ad_range,
    output logic             caiji_flag,
    output logic             ready,
    output logic             overrun,
    output logic [15:0]      overrun_cnt,
    output logic             timeout_err,
    output logic [15:0]      sample_cnt
);

    typedef enum logic [2:0] {
        ST_RST_ADC,
        ST_SETTLE,
        ST_IDLE,
        ST_TRIG,
        ST_WAIT
    } state_t;

    localparam logic [31:0]      RST_LAST    = 32'(RST_CYCLES - 1);
    localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      WAIT_LAST   = 32'(TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_ONE     = PER_W'(1);

    state_t           state_q;
    logic [31:0]      seq_cnt_q;      // shared by RST_ADC, SETTLE and WAIT
    logic [PER_W-1:0] tmr_q, tmr_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] per_eff;
    logic             timer_run;
    logic             tick;
    logic             in_conv;

    logic             ad_reset_q;
    logic [2:0]       ad_os_q;
    logic             ad_range_q;
    logic             caiji_flag_q;
    logic             ready_q;
    logic             overrun_q;
    logic [15:0]      overrun_cnt_q;
    logic             timeout_err_q;
    logic [15:0]      sample_cnt_q;

    assign ad_reset    = ad_reset_q;
    assign ad_os       = ad_os_q;
    assign ad_range    = ad_range_q;
    assign caiji_flag  = caiji_flag_q;
    assign ready       = ready_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;
    assign timeout_err = timeout_err_q;
    assign sample_cnt  = sample_cnt_q;

    assign in_conv = (state_q == ST_TRIG) || (state_q == ST_WAIT);

    // Trigger timer. The interval is captured on the first count of every
    // lap (count 0), so a new period only applies after the current lap wraps.
    always_comb begin
        timer_run = enable && (period != '0) &&
                    ((state_q == ST_IDLE) || in_conv);
        per_eff   = (tmr_q == '0) ? period : per_q;
        tick      = timer_run && (tmr_q == per_eff - PER_ONE);
        tmr_d     = '0;
        per_d     = per_q;
        if (timer_run) begin
            if (tmr_q == '0) begin
                per_d = period;
            end
            tmr_d = tick ? '0 : tmr_q + PER_ONE;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            tmr_q <= '0;
            per_q <= '0;
        end else begin
            tmr_q <= tmr_d;
            per_q <= per_d;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q       <= ST_RST_ADC;
            seq_cnt_q     <= '0;
            ad_reset_q    <= 1'b1;
            ad_os_q       <= '0;
            ad_range_q    <= 1'b0;
            caiji_flag_q  <= 1'b0;
            ready_q       <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
            timeout_err_q <= 1'b0;
            sample_cnt_q  <= '0;
        end else begin
            caiji_flag_q <= 1'b0;

            // Config pins stay frozen for the whole conversion.
            if (!in_conv) begin
                ad_os_q    <= os_sel;
                ad_range_q <= range_sel;
            end

            // Clear first; set events below override it in the same cycle.
            if (clear_err) begin
                overrun_q     <= 1'b0;
                overrun_cnt_q <= '0;
                timeout_err_q <= 1'b0;
                sample_cnt_q  <= '0;
            end

            if (tick && in_conv) begin
                overrun_q <= 1'b1;
                if (clear_err) begin
                    overrun_cnt_q <= 16'd1;
                end else if (overrun_cnt_q != 16'hFFFF) begin
                    overrun_cnt_q <= overrun_cnt_q + 16'd1;
                end
            end

            case (state_q)
                ST_RST_ADC: begin
                    if (seq_cnt_q == RST_LAST) begin
                        state_q    <= ST_SETTLE;
                        ad_reset_q <= 1'b0;
                        seq_cnt_q  <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 32'd1;
                    end
                end
                ST_SETTLE: begin
                    if (seq_cnt_q == SETTLE_LAST) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        seq_cnt_q <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 32'd1;
                    end
                end
                ST_IDLE: begin
                    if (reinit) begin
                        state_q    <= ST_RST_ADC;
                        ad_reset_q <= 1'b1;
                        ready_q    <= 1'b0;
                        seq_cnt_q  <= '0;
                    end else if (tick || single_shot) begin
                        state_q      <= ST_TRIG;
                        caiji_flag_q <= 1'b1;
                        ready_q      <= 1'b0;
                    end
                end
                ST_TRIG: begin
                    state_q   <= ST_WAIT;
                    seq_cnt_q <= '0;
                end
                ST_WAIT: begin
                    // rd_done is checked first so a last-cycle finish is not an error.
                    if (rd_done) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        if (clear_err) begin
                            sample_cnt_q <= 16'd1;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 16'd1;
                        end
                    end else if (seq_cnt_q == WAIT_LAST) begin
                        state_q       <= ST_RST_ADC;
                        ad_reset_q    <= 1'b1;
                        timeout_err_q <= 1'b1;
                        seq_cnt_q     <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q    <= ST_RST_ADC;
                    ad_reset_q <= 1'b1;
                    ready_q    <= 1'b0;
                    seq_cnt_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad7606_sample_sched.sv
// tb/tb_ad7606_sample_sched.sv - self-checking bench for ad7606_sample_sched
module tb_ad7606_sample_sched;

    localparam int RST_CYC    = 10;
    localparam int SETTLE_CYC = 100;
    localparam int TMO        = 4096;
    localparam int PW         = 24;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] period = '0;
    logic          single_shot = 1'b0;
    logic [2:0]    os_sel = 3'd0;
    logic          range_sel = 1'b0;
    logic          reinit = 1'b0;
    logic          clear_err = 1'b0;
    logic          rd_done = 1'b0;
    logic          ad_reset;
    logic [2:0]    ad_os;
    logic          ad_range;
    logic          caiji_flag;
    logic          ready;
    logic          overrun;
    logic [15:0]   overrun_cnt;
    logic          timeout_err;
    logic [15:0]   sample_cnt;

    always #5 clk = ~clk;

    ad7606_sample_sched #(
        .RST_CYCLES(RST_CYC), .SETTLE_CYCLES(SETTLE_CYC), .TIMEOUT(TMO), .PER_W(PW)
    ) dut (
        .clk(clk), .res(res), .enable(enable), .period(period),
        .single_shot(single_shot), .os_sel(os_sel), .range_sel(range_sel),
        .reinit(reinit), .clear_err(clear_err), .rd_done(rd_done),
        .ad_reset(ad_reset), .ad_os(ad_os), .ad_range(ad_range),
        .caiji_flag(caiji_flag), .ready(ready), .overrun(overrun),
        .overrun_cnt(overrun_cnt), .timeout_err(timeout_err), .sample_cnt(sample_cnt)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum int {PH_RST, PH_SETTLE, PH_IDLE, PH_TRIG, PH_WAIT} ph_t;

    longint cyc = 0;
    ph_t    m_ph = PH_RST;
    int     m_left = RST_CYC;     // cycles still to spend in RST/SETTLE
    int     m_age = 0;            // WAIT cycles elapsed
    bit     m_timer_on = 1'b0;    // a tick deadline is armed
    longint m_due = 0;            // absolute cycle of the armed tick
    bit     m_ovr = 1'b0;
    bit     m_tmo = 1'b0;
    int     m_ovr_cnt = 0;
    int     m_samples = 0;
    int     m_os = 0;
    int     m_rng = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge res) begin : model
        ph_t    n_ph;
        int     n_left, n_age, n_ocnt, n_samp;
        bit     n_on, n_ovr, n_tmo, tick, running, busy;
        longint n_due;
        if (res) begin
            m_ph <= PH_RST; m_left <= RST_CYC; m_age <= 0;
            m_timer_on <= 1'b0; m_due <= 0;
            m_ovr <= 1'b0; m_tmo <= 1'b0; m_ovr_cnt <= 0; m_samples <= 0;
            m_os <= 0; m_rng <= 0;
        end else begin
            n_ph = m_ph; n_left = m_left; n_age = m_age;
            n_on = m_timer_on; n_due = m_due;
            n_ovr = m_ovr; n_tmo = m_tmo; n_ocnt = m_ovr_cnt; n_samp = m_samples;
            busy    = (m_ph == PH_TRIG) || (m_ph == PH_WAIT);
            running = enable && (period != '0) && (busy || m_ph == PH_IDLE);
            tick    = 1'b0;
            if (!running) begin
                n_on = 1'b0;
            end else begin
                // a fresh lap fixes its deadline from the period seen now
                if (!m_timer_on) n_due = cyc + longint'(period) - 1;
                tick = (cyc == n_due);
                n_on = !tick;
            end
            if (clear_err) begin
                n_ovr = 1'b0; n_tmo = 1'b0; n_ocnt = 0; n_samp = 0;
            end
            if (tick && busy) begin
                n_ovr = 1'b1;
                if (n_ocnt < 65535) n_ocnt++;
            end
            if (!busy) begin
                m_os <= int'(os_sel);
                m_rng <= int'(range_sel);
            end
            case (m_ph)
                PH_RST: begin
                    n_left--;
                    if (n_left == 0) begin n_ph = PH_SETTLE; n_left = SETTLE_CYC; end
                end
                PH_SETTLE: begin
                    n_left--;
                    if (n_left == 0) n_ph = PH_IDLE;
                end
                PH_IDLE: begin
                    if (reinit) begin n_ph = PH_RST; n_left = RST_CYC; end
                    else if (tick || single_shot) n_ph = PH_TRIG;
                end
                PH_TRIG: begin n_ph = PH_WAIT; n_age = 0; end
                PH_WAIT: begin
                    n_age++;
                    if (rd_done) begin
                        n_ph = PH_IDLE;
                        n_samp = (n_samp + 1) % 65536;
                    end else if (n_age == TMO) begin
                        n_tmo = 1'b1; n_ph = PH_RST; n_left = RST_CYC;
                    end
                end
                default: ;
            endcase
            m_ph <= n_ph; m_left <= n_left; m_age <= n_age;
            m_timer_on <= n_on; m_due <= n_due;
            m_ovr <= n_ovr; m_tmo <= n_tmo; m_ovr_cnt <= n_ocnt; m_samples <= n_samp;
        end
    end

    // ---------------- compare process ----------------
    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            check("cmp_ad_reset", ad_reset, (m_ph == PH_RST) ? 1 : 0);
            check("cmp_ready", ready, (m_ph == PH_IDLE) ? 1 : 0);
            check("cmp_caiji_flag", caiji_flag, (m_ph == PH_TRIG) ? 1 : 0);
            check("cmp_ad_os", ad_os, m_os);
            check("cmp_ad_range", ad_range, m_rng);
            check("cmp_overrun", overrun, m_ovr);
            check("cmp_overrun_cnt", overrun_cnt, m_ovr_cnt);
            check("cmp_timeout_err", timeout_err, m_tmo);
            check("cmp_sample_cnt", sample_cnt, m_samples);
        end
    end

    longint flag_q[$];
    always @(negedge clk) if (caiji_flag === 1'b1) flag_q.push_back(cyc);

    // ---------------- stimulus ----------------
    int rd_delay = 0;   // fixed reader latency, 0 = reader silent
    bit rand_rd = 1'b0; // random reader latency
    int rd_cd = -1;

    task automatic step();
        @(posedge clk);
        #1;
        single_shot = 1'b0;
        reinit = 1'b0;
        clear_err = 1'b0;
        if (m_ph == PH_TRIG && (rand_rd || rd_delay > 0))
            rd_cd = rand_rd ? int'($urandom_range(1, 80)) : rd_delay;
        else if (rd_cd >= 0)
            rd_cd--;
        rd_done = (rd_cd == 0);
    endtask

    task automatic wait_ready(string name, int budget);
        int n = 0;
        while (!ready && n < budget) begin step(); n++; end
        check(name, ready, 1);
    endtask

    initial begin
        int n;
        bit early;
        #1 res = 1'b1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        check("rst_ad_reset", ad_reset, 1);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_ready", ready, 0);
        @(posedge clk); #1;
        res = 1'b0;

        // 1: power-on reset pulse and settling
        n = 0;
        while (ad_reset && n < 50) begin step(); n++; end
        check("t1_reset_width", n, 10);
        n = 0; early = 1'b0;
        while (!ready && n < 500) begin
            if (caiji_flag) early = 1'b1;
            step(); n++;
        end
        check("t1_settle_len", n, 100);
        check("t1_no_early_flag", early, 0);

        // 2: periodic triggering, 1000-cycle period, 300-cycle reader
        flag_q.delete();
        rd_delay = 300; period = PW'(1000); enable = 1'b1;
        n = 0;
        while (flag_q.size() < 5 && n < 6000) begin step(); n++; end
        check("t2_flag_count", flag_q.size(), 5);
        for (int i = 1; i < flag_q.size(); i++)
            check("t2_flag_spacing", flag_q[i] - flag_q[i-1], 1000);
        repeat (310) step();
        check("t2_sample_cnt", sample_cnt, 5);
        check("t2_overrun", overrun, 0);
        enable = 1'b0;

        // 3: period shorter than the conversion drops every other tick
        flag_q.delete();
        period = PW'(200); enable = 1'b1;
        n = 0;
        while (flag_q.size() < 4 && n < 3000) begin step(); n++; end
        check("t3_flag_count", flag_q.size(), 4);
        if (flag_q.size() >= 4) check("t3_span", flag_q[3] - flag_q[0], 1200);
        check("t3_overrun", overrun, 1);
        check("t3_overrun_cnt", overrun_cnt, 3);
        enable = 1'b0;
        repeat (320) step();

        // 4: single-shot, second request during WAIT ignored
        clear_err = 1'b1;
        step();
        check("t4_clr_sample", sample_cnt, 0);
        check("t4_clr_ovr_cnt", overrun_cnt, 0);
        flag_q.delete();
        rd_delay = 50;
        single_shot = 1'b1;
        step();
        check("t4_flag_next", caiji_flag, 1);
        repeat (5) step();
        single_shot = 1'b1;
        step();
        check("t4_no_flag_wait", caiji_flag, 0);
        repeat (100) step();
        check("t4_one_flag", flag_q.size(), 1);
        check("t4_sample_cnt", sample_cnt, 1);

        // 5: silent reader -> timeout, ADC re-init, clear
        rd_delay = 0;
        single_shot = 1'b1;
        step();
        check("t5_flag", caiji_flag, 1);
        n = 0;
        while (!timeout_err && n < 5000) begin step(); n++; end
        check("t5_timeout_delay", n, 4097);
        n = 0;
        while (ad_reset && n < 50) begin step(); n++; end
        check("t5_reset_width", n, 10);
        wait_ready("t5_ready_back", 200);
        clear_err = 1'b1;
        step();
        check("t5_tmo_cleared", timeout_err, 0);
        check("t5_sample_cleared", sample_cnt, 0);

        // 6: config pins frozen during a conversion, reset mid-WAIT
        os_sel = 3'b000;
        repeat (3) step();
        rd_delay = 40;
        single_shot = 1'b1;
        step();
        repeat (3) step();
        os_sel = 3'b011;
        repeat (5) step();
        check("t6_os_frozen", ad_os, 0);
        wait_ready("t6_ready", 100);
        check("t6_os_first_idle", ad_os, 0);
        step();
        check("t6_os_loaded", ad_os, 3);
        single_shot = 1'b1;
        step();
        repeat (5) step();
        res = 1'b1;
        #1;
        check("t6_res_ad_reset", ad_reset, 1);
        check("t6_res_ready", ready, 0);
        check("t6_res_ad_os", ad_os, 0);
        check("t6_res_sample", sample_cnt, 0);
        check("t6_res_caiji", caiji_flag, 0);
        step(); step();
        res = 1'b0;
        wait_ready("t6_ready_after_res", 200);

        // randomized traffic against the model
        rand_rd = 1'b1;
        period = PW'(13);
        enable = 1'b1;
        for (int i = 0; i < 15000; i++) begin
            step();
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 499) == 0) period = PW'($urandom_range(0, 40));
            single_shot = ($urandom_range(0, 15) == 0);
            reinit = ($urandom_range(0, 399) == 0);
            clear_err = ($urandom_range(0, 149) == 0);
            os_sel = 3'($urandom_range(0, 7));
            range_sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) rd_done = 1'b1;
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog @%0t: got no finish, expected finish", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad7606_sample_sched.md
Name: ad7606_sample_sched

Overview:
Sequencer for the AD7606 serial reader.
- Issues the ADC power-on RESET pulse and holds off during settling.
- Generates the single-cycle `caiji_flag` start pulse, either from a programmable periodic timer or from a software single-shot request.
- Waits for the reader's end-of-frame pulse, watches for timeouts, counts overruns, and drives the ADC static configuration pins (OS, RANGE).

Parameters:
- RST_CYCLES, 10: width of the `ad_reset` pulse in clk cycles (≥2).
- SETTLE_CYCLES, 100: idle wait after `ad_reset` falls, before the first trigger.
- TIMEOUT, 4096: max cycles from `caiji_flag` to `rd_done` before error.
- PER_W, 24: width of `period`.

Ports:
- clk  in  1  system clock
- res  in  1  asynchronous reset, active-high
- enable  in  1  periodic triggering enable
- period  in  PER_W  trigger interval in clk cycles; 0 disables the timer
- single_shot  in  1  one-cycle request for one conversion
- os_sel  in  3  oversampling select for the ADC
- range_sel  in  1  input range select (0=±5V, 1=±10V)
- reinit  in  1  one-cycle request to rerun the ADC reset sequence
- clear_err  in  1  one-cycle clear of sticky flags and counters
- rd_done  in  1  end-of-frame pulse from the reader (all 8 channels stored)
- ad_reset  out  1  ADC RESET pin, active-high
- ad_os  out  3  ADC OS[2:0] pins
- ad_range  out  1  ADC RANGE pin
- caiji_flag  out  1  one-cycle start pulse to the reader
- ready  out  1  high in IDLE only
- overrun  out  1  sticky: a timer tick was dropped
- overrun_cnt  out  16  dropped ticks, saturating at 16'hFFFF
- timeout_err  out  1  sticky: `rd_done` not seen within TIMEOUT
- sample_cnt  out  16  completed frames, wraps at 16'hFFFF→0

Behaviour:
- All outputs registered.
- Reset values:
  - `ad_reset` = 1; all other outputs 0.
  - state = RST_ADC; internal counters 0.
- Asserting `res` at any time aborts the sequence immediately and returns every output to its reset value.
- States and transitions:
  - RST_ADC: `ad_reset` = 1 for RST_CYCLES cycles, then go to SETTLE with `ad_reset` = 0.
  - SETTLE: count SETTLE_CYCLES cycles, then go to IDLE.
  - IDLE: `ready` = 1.
    - Trigger when (timer tick) or (`single_shot`); go to TRIG.
    - `reinit` has priority over a trigger; go to RST_ADC.
  - TRIG: `caiji_flag` = 1 for exactly this one cycle; next state WAIT.
    - The flag is high the cycle after the trigger condition was sampled in IDLE.
  - WAIT: timeout counter increments each cycle.
    - `rd_done` = 1: `sample_cnt`++, go to IDLE.
    - Counter reaches TIMEOUT-1 without `rd_done`: set `timeout_err`, go to RST_ADC (ADC re-initialised).
    - `rd_done` on the same cycle as the timeout: done wins; no error.
- Timer:
  - Counts 0..period-1 while `enable` = 1 and period ≠ 0, in states IDLE/TRIG/WAIT.
  - Tick = terminal count.
  - The counter is held at 0 when `enable` = 0, period = 0, or state is RST_ADC/SETTLE.
  - `period` = 1 ticks every cycle.
  - A change of `period` takes effect at the next wrap.
- Overrun: a tick while in TRIG or WAIT sets `overrun` and increments `overrun_cnt` (saturating); the tick is dropped, not queued.
- Collisions and ignored inputs:
  - `single_shot` outside IDLE is ignored silently.
  - Tick and `single_shot` on the same IDLE cycle produce one trigger.
  - `rd_done` outside WAIT is ignored.
  - `reinit` outside IDLE is ignored.
- Config pins:
  - `ad_os`/`ad_range` load from `os_sel`/`range_sel` only while in IDLE, RST_ADC or SETTLE.
  - They are frozen during TRIG/WAIT, so the pins never change mid-conversion.
- `clear_err`:
  - Clears `overrun`, `overrun_cnt`, `timeout_err` and `sample_cnt` next cycle.
  - If a set event and `clear_err` occur on the same cycle, set wins (the flag remains 1, count = 1).

Test Plan:
1. Release `res` → `ad_reset` high for 10 cycles, low thereafter; `ready` rises 100 cycles after `ad_reset` falls; no `caiji_flag` before `ready`.
2. enable = 1, period = 1000, model `rd_done` 300 cycles after each `caiji_flag` → `caiji_flag` spacing exactly 1000; after 5 frames `sample_cnt` = 5, `overrun` = 0.
3. period = 200, `rd_done` delay 300 → `overrun` = 1 and `overrun_cnt` increments once per dropped tick; `caiji_flag` never appears outside IDLE→TRIG.
4. enable = 0, `single_shot` pulse in IDLE → `caiji_flag` exactly 1 cycle later; second `single_shot` during WAIT produces no flag; `sample_cnt` +1 only.
5. No `rd_done` after a trigger → `timeout_err` = 1 after 4096 cycles, `ad_reset` pulses 10 cycles, `ready` returns; `clear_err` → `timeout_err` = 0, `sample_cnt` = 0.
6. Change `os_sel` 3'b000→3'b011 during WAIT → `ad_os` stays 000 until IDLE, then 011; assert `res` mid-WAIT → `ad_reset` = 1 and all other outputs 0 immediately.
